// File: rtl/sph_surf_acc_mc_if.sv
// Stream and result-handshake bundle for the multi-channel frame accumulator.
// The producer/consumer side uses the master modport and the accumulator uses the slave modport.
interface sph_surf_acc_mc_if #(
    parameter int DIN_W = 26,
    parameter int ACC_W = 32,
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH*DIN_W-1:0] din;
    logic                  din_valid;
    logic                  en;
    logic [N_CH*ACC_W-1:0] dout;
    logic [CNT_W-1:0]      dout_cnt;
    logic [N_CH-1:0]       dout_sat;
    logic                  dout_ovr;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output din, din_valid, en, dout_ready,
        input  dout, dout_cnt, dout_sat, dout_ovr, dout_valid
    );

    modport slave (
        input  din, din_valid, en, dout_ready,
        output dout, dout_cnt, dout_sat, dout_ovr, dout_valid
    );
endinterface

// File: rtl/sph_surf_acc_mc.sv
// Saturating multi-channel frame accumulator with a held valid/ready result register,
// so the next frame can accumulate while the previous totals wait to be consumed.
module sph_surf_acc_mc #(
    parameter int DIN_W = 26,
    parameter int ACC_W = 32,
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    sph_surf_acc_mc_if.slave bus
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [ACC_W-1:0] sext(input logic [DIN_W-1:0] b);
        sext = {{(ACC_W-DIN_W){b[DIN_W-1]}}, b};
    endfunction

    // Returns {clamped, value}; the two top bits of the ACC_W+1 sum disagree only on overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [DIN_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[DIN_W-1], sext(b)};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                sat_add = {1'b1, ACC_MIN};
            end else begin
                sat_add = {1'b1, ACC_MAX};
            end
        end else begin
            sat_add = {1'b0, sum[ACC_W-1:0]};
        end
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ACC_W-1:0]      r_acc     [N_CH];
    logic [ACC_W-1:0]      w_acc_nxt [N_CH];
    logic [ACC_W:0]        w_sum     [N_CH];
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [N_CH-1:0]       r_sat;
    logic [N_CH-1:0]       w_sat_nxt;
    logic                  w_publish;
    logic [N_CH*ACC_W-1:0] r_dout;
    logic [CNT_W-1:0]      r_dout_cnt;
    logic [N_CH-1:0]       r_dout_sat;
    logic                  r_dout_ovr;
    logic                  r_dout_valid;

    // Per-channel saturating sum of the running total and the incoming sample.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_sum[c] = sat_add(r_acc[c], bus.din[c*DIN_W +: DIN_W]);
        end
    end

    // Next-state and next accumulator/counter/flag values.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        w_publish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (bus.din_valid) begin
                            w_acc_nxt[c] = sext(bus.din[c*DIN_W +: DIN_W]);
                        end else begin
                            w_acc_nxt[c] = {ACC_W{1'b0}};
                        end
                    end
                    w_cnt_nxt   = {{(CNT_W-1){1'b0}}, bus.din_valid};
                    w_sat_nxt   = {N_CH{1'b0}};
                    w_state_nxt = S_ACC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC: begin
                if (bus.en) begin
                    if (bus.din_valid) begin
                        for (int c = 0; c < N_CH; c++) begin
                            w_acc_nxt[c] = w_sum[c][ACC_W-1:0];
                            w_sat_nxt[c] = r_sat[c] | w_sum[c][ACC_W];
                        end
                        if (r_cnt != CNT_MAX) begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end else begin
                            w_cnt_nxt = r_cnt;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end else begin
                    // Sample on the frame-end cycle is dropped.
                    w_publish   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, sample counter and sticky saturation flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_acc[c] <= {ACC_W{1'b0}};
            end
            r_cnt <= {CNT_W{1'b0}};
            r_sat <= {N_CH{1'b0}};
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_sat <= w_sat_nxt;
        end
    end

    // Result register: a publish takes priority over a coincident handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= {(N_CH*ACC_W){1'b0}};
            r_dout_cnt   <= {CNT_W{1'b0}};
            r_dout_sat   <= {N_CH{1'b0}};
            r_dout_ovr   <= 1'b0;
            r_dout_valid <= 1'b0;
        end else if (w_publish) begin
            for (int c = 0; c < N_CH; c++) begin
                r_dout[c*ACC_W +: ACC_W] <= r_acc[c];
            end
            r_dout_cnt   <= r_cnt;
            r_dout_sat   <= r_sat;
            r_dout_ovr   <= r_dout_valid & ~bus.dout_ready;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid & bus.dout_ready) begin
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_dout_valid;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_cnt   = r_dout_cnt;
    assign bus.dout_sat   = r_dout_sat;
    assign bus.dout_ovr   = r_dout_ovr;
    assign bus.dout_valid = r_dout_valid;
endmodule

// File: tb/tb_sph_surf_acc_mc.sv
// Directed bench for sph_surf_acc_mc: hand-computed frame totals, saturation,
// backpressure, publish/handshake collision and mid-frame reset.
module tb_sph_surf_acc_mc;
    localparam int DIN_W = 26;
    localparam int ACC_W = 32;
    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    sph_surf_acc_mc_if #(.DIN_W(DIN_W), .ACC_W(ACC_W), .N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    sph_surf_acc_mc #(.DIN_W(DIN_W), .ACC_W(ACC_W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N_CH*DIN_W-1:0] pk(input int a, input int b, input int c, input int d);
        pk = {d[DIN_W-1:0], c[DIN_W-1:0], b[DIN_W-1:0], a[DIN_W-1:0]};
    endfunction

    function automatic logic [31:0] lane(input int c);
        lane = bus.dout[c*ACC_W +: ACC_W];
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic v, input logic [N_CH*DIN_W-1:0] d);
        bus.en        = e;
        bus.din_valid = v;
        bus.din       = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0);
        bus.dout_ready = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("rst_dout0", lane(0), 32'd0);
        chk("rst_dout3", lane(3), 32'd0);
        chk("rst_cnt", {16'd0, bus.dout_cnt}, 32'd0);
        chk("rst_sat", {28'd0, bus.dout_sat}, 32'd0);
        chk("rst_ovr", {31'd0, bus.dout_ovr}, 32'd0);
        rst = 1'b0;

        // 1. Basic frame
        drive(1'b1, 1'b1, pk(100, -5, 0, 33554431));
        cyc(4);
        chk("t1_pre_valid", {31'd0, bus.dout_valid}, 32'd0);
        drive(1'b0, 1'b0, '0);
        cyc(1);
        chk("t1_valid", {31'd0, bus.dout_valid}, 32'd1);
        chk("t1_ch0", lane(0), 32'd400);
        chk("t1_ch1", lane(1), 32'hFFFF_FFEC);
        chk("t1_ch2", lane(2), 32'd0);
        chk("t1_ch3", lane(3), 32'd134217724);
        chk("t1_cnt", {16'd0, bus.dout_cnt}, 32'd4);
        chk("t1_sat", {28'd0, bus.dout_sat}, 32'd0);
        chk("t1_ovr", {31'd0, bus.dout_ovr}, 32'd0);
        cyc(2);
        chk("t1_hold_ch0", lane(0), 32'd400);
        chk("t1_hold_valid", {31'd0, bus.dout_valid}, 32'd1);
        bus.dout_ready = 1'b1;
        cyc(1);
        chk("t1_consumed", {31'd0, bus.dout_valid}, 32'd0);
        bus.dout_ready = 1'b0;

        // 2. Valid gaps: pattern 1,0,1,0,0,1
        drive(1'b1, 1'b1, pk(7, 0, 0, 0)); cyc(1);
        drive(1'b1, 1'b0, pk(9, 9, 9, 9)); cyc(1);
        drive(1'b1, 1'b1, pk(7, 0, 0, 0)); cyc(1);
        drive(1'b1, 1'b0, pk(9, 9, 9, 9)); cyc(2);
        drive(1'b1, 1'b1, pk(7, 0, 0, 0)); cyc(1);
        drive(1'b0, 1'b1, pk(50, 50, 50, 50)); cyc(1);
        chk("t2_ch0", lane(0), 32'd21);
        chk("t2_ch1", lane(1), 32'd0);
        chk("t2_cnt", {16'd0, bus.dout_cnt}, 32'd3);
        bus.dout_ready = 1'b1;
        drive(1'b0, 1'b0, '0);
        cyc(1);
        bus.dout_ready = 1'b0;

        // 3. Saturation over 70 samples
        drive(1'b1, 1'b1, pk(33554431, -33554432, 1, -1));
        cyc(70);
        drive(1'b0, 1'b0, '0);
        cyc(1);
        chk("t3_ch0", lane(0), 32'h7FFF_FFFF);
        chk("t3_ch1", lane(1), 32'h8000_0000);
        chk("t3_ch2", lane(2), 32'd70);
        chk("t3_ch3", lane(3), 32'hFFFF_FFBA);
        chk("t3_sat", {28'd0, bus.dout_sat}, 32'd3);
        chk("t3_cnt", {16'd0, bus.dout_cnt}, 32'd70);
        bus.dout_ready = 1'b1;
        cyc(1);
        bus.dout_ready = 1'b0;

        // 3b. Exactly 64 samples of the negative limit: reaches it without clamping
        drive(1'b1, 1'b1, pk(0, -33554432, 0, 0));
        cyc(64);
        drive(1'b0, 1'b0, '0);
        cyc(1);
        chk("t3b_ch1", lane(1), 32'h8000_0000);
        chk("t3b_sat", {28'd0, bus.dout_sat}, 32'd0);
        bus.dout_ready = 1'b1;
        cyc(1);
        bus.dout_ready = 1'b0;

        // 4. Backpressure across two frames
        drive(1'b1, 1'b1, pk(10, 0, 0, 0)); cyc(1);
        drive(1'b0, 1'b0, '0); cyc(1);
        chk("t4_a_ch0", lane(0), 32'd10);
        chk("t4_a_ovr", {31'd0, bus.dout_ovr}, 32'd0);
        drive(1'b1, 1'b1, pk(10, 0, 0, 0)); cyc(2);
        drive(1'b0, 1'b0, '0); cyc(1);
        chk("t4_b_ch0", lane(0), 32'd20);
        chk("t4_b_cnt", {16'd0, bus.dout_cnt}, 32'd2);
        chk("t4_b_ovr", {31'd0, bus.dout_ovr}, 32'd1);
        chk("t4_b_valid", {31'd0, bus.dout_valid}, 32'd1);
        bus.dout_ready = 1'b1;
        cyc(1);
        chk("t4_drop_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("t4_data_hold", lane(0), 32'd20);
        bus.dout_ready = 1'b0;

        // 5. Publish coincides with handshake
        drive(1'b1, 1'b1, pk(5, 0, 0, 0)); cyc(1);
        drive(1'b0, 1'b0, '0); cyc(1);
        chk("t5_a_ch0", lane(0), 32'd5);
        drive(1'b1, 1'b1, pk(3, 0, 0, 0)); cyc(2);
        drive(1'b0, 1'b0, '0);
        bus.dout_ready = 1'b1;
        cyc(1);
        chk("t5_valid", {31'd0, bus.dout_valid}, 32'd1);
        chk("t5_ch0", lane(0), 32'd6);
        chk("t5_ovr", {31'd0, bus.dout_ovr}, 32'd0);
        cyc(1);
        chk("t5_drop_valid", {31'd0, bus.dout_valid}, 32'd0);
        bus.dout_ready = 1'b0;

        // 6. Reset mid-frame, then en high right after reset release
        drive(1'b1, 1'b1, pk(7, 1, 1, 1)); cyc(3);
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_ch0", lane(0), 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b1, pk(7, 0, 0, 0)); cyc(1);
        chk("t6_no_valid_a", {31'd0, bus.dout_valid}, 32'd0);
        cyc(1);
        drive(1'b0, 1'b0, '0); 
        chk("t6_no_valid_b", {31'd0, bus.dout_valid}, 32'd0);
        cyc(1);
        chk("t6_ch0", lane(0), 32'd14);
        chk("t6_ch1", lane(1), 32'd0);
        chk("t6_cnt", {16'd0, bus.dout_cnt}, 32'd2);
        chk("t6_valid", {31'd0, bus.dout_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sph_surf_acc_mc.md
# sph_surf_acc_mc

Multi-channel, parametrised frame accumulator for the sphere-surface processing path. It sums N_CH signed sample streams over an `en`-delimited frame, using saturating arithmetic and a per-frame sample count. At frame end it publishes the totals through a held valid/ready output register, so a new frame can accumulate while the previous result waits to be consumed.

## Interface
Parameters:
- `DIN_W`, 26: signed input sample width per channel.
- `ACC_W`, 32: signed accumulator and output width per channel. Must be greater than `DIN_W`.
- `N_CH`, 4: number of channels.
- `CNT_W`, 16: sample-counter width.

Ports:
- `clk`, in, 1: single clock; all logic runs on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `din`, in, N_CH*DIN_W: packed signed samples; channel c occupies bits [c*DIN_W +: DIN_W].
- `din_valid`, in, 1: samples on `din` are valid this cycle.
- `en`, in, 1: frame window; high means accumulate.
- `dout`, out, N_CH*ACC_W: packed signed frame totals, channel c at [c*ACC_W +: ACC_W].
- `dout_cnt`, out, CNT_W: number of valid samples accumulated in the published frame.
- `dout_sat`, out, N_CH: per-channel flag; set if that channel saturated at any point during the published frame.
- `dout_ovr`, out, 1: set if the published result overwrote an unconsumed previous result.
- `dout_valid`, out, 1: result available.
- `dout_ready`, in, 1: consumer accepts the result.

## Operation
Accumulator FSM, two states:
- **IDLE**
  - If `en`=1: each `acc[c]` loads sext(`din[c]`) when `din_valid`=1, else 0.
  - `cnt` loads `din_valid`; `sat` clears; go to ACC.
  - If `en`=0: stay in IDLE; accumulators hold.
- **ACC**
  - If `en`=1 and `din_valid`=1: for each c, `acc[c]` ← sat(`acc[c]` + sext(`din[c]`)); `cnt` ← min(`cnt`+1, 2^CNT_W−1).
  - If `en`=1 and `din_valid`=0: hold.
  - If `en`=0: frame end. The sample on this cycle is ignored. Publish `acc`, `cnt`, `sat` to the output register; go to IDLE.

Arithmetic:
- Each sum is formed in ACC_W+1 bits.
- A result above 2^(ACC_W−1)−1 clamps to that value; a result below −2^(ACC_W−1) clamps to that value.
- Any clamp sets `sat[c]` sticky for the rest of the frame.
- The IDLE first-sample load never saturates.

Output register (publish):
- `dout`, `dout_cnt`, and `dout_sat` load; `dout_valid` ← 1.
- `dout_ovr` ← `dout_valid` & ~`dout_ready`, evaluated in the publish cycle, i.e. the old result was still pending and not accepted.
- The handshake completes on any cycle with `dout_valid`=1 and `dout_ready`=1.
- If a handshake and a publish occur in the same cycle, the publish wins: `dout_valid` stays 1, the new data loads, and `ovr`=0.
- After a handshake with no simultaneous publish, `dout_valid` ← 0 and data holds.
- Data and flags are stable while `dout_valid`=1 and no publish occurs.

Back-to-back frames need at least one cycle with `en`=0 between them.

## Timing
- Reset values: all outputs 0; FSM in IDLE; accumulators, counter, and `sat` all 0.
- Reset mid-frame discards the partial frame and any pending result; no `dout_valid` follows.
- A sample presented in cycle k is included in `acc` at the k+1 edge.
- Frame-end latency: the first `en`=0 cycle is cycle t; `dout_valid`=1 and the data are visible from cycle t+1.
- `dout_valid` falls the cycle after the accepting handshake, unless a publish coincides with it.
- `en` high directly after reset release is legal: that cycle is handled as IDLE with `en`=1.
- Counter saturation at 2^CNT_W−1 does not set any flag.
- All outputs are registered; there is no combinational path from `din` to any output, and no combinational path from `dout_ready` to `dout_valid`.

## Test plan
1. **Basic frame.** Reset, then `en`=1 for 4 cycles with `din_valid`=1 and ch0=100, ch1=−5, ch2=0, ch3=33554431, then `en`=0 → next cycle `dout`={400, −20, 0, 134217724}, `cnt`=4, `sat`=0, `ovr`=0, `dout_valid`=1.
2. **Valid gaps.** `en`=1 for 6 cycles, `din_valid` high on 3 of them with ch0=7 → ch0=21, `cnt`=3.
3. **Saturation.** ch0=33554431 and ch1=−33554432 on every cycle for 70 valid cycles → ch0=2147483647 with `sat[0]`=1; ch1=−2147483648 with `sat[1]`=1 (ch1 reaches the limit exactly at 64 samples and is flagged at sample 65); `cnt`=70.
4. **Backpressure.** Hold `dout_ready`=0 through two complete frames (ch0 totals 10, then 20) → `dout` ch0=20, `ovr`=1. Raise `ready` → `dout_valid`=0 on the next cycle.
5. **Publish coincides with handshake.** Frame end lands on the same cycle as `ready`=1 for the pending result → `dout_valid` stays 1, new data loads, `ovr`=0.
6. **Reset mid-frame.** Assert `rst` after 3 samples → `dout_valid` remains 0. A following frame of 2 samples of ch0=7 → ch0=14, `cnt`=2.
